vx_operands_lane_serializer: RTL
================================

// Module: vx_operands_lane_serializer
// PURPOSE
//  Consumer (slave) end of the operands valid/data/ready interface, placed in front of an execute unit
//  that has fewer lanes than the warp has threads. Buffers one full-warp operand packet and replays it
//  as NUM_LANES-wide beats, tagged with batch id (pid) and start/end-of-packet flags. Batches whose
//  tmask slice is zero are skipped.
// PARAMETERS
//  THREAD_CNT  `NUM_THREADS  threads per operand packet; must be a multiple of NUM_LANES
//  NUM_LANES   2             lanes per output beat; equal to THREAD_CNT gives a 1-beat passthrough
//  BATCHES     THREAD_CNT/NUM_LANES (localparam); PID_W = max(1, clog2(BATCHES))
// PORTS
//  clk        in   1            clock
//  reset_n    in   1            asynchronous, active-low reset
//  in_valid   in   1            operand packet valid
//  in_data    in   OPS_DATAW    operand packet: uuid, wis, tmask, PC, ex/op type, mod, wb, use_PC/imm,
//                               imm, rd, rs1/rs2/rs3 per thread, is_branch
//  in_ready   out  1            packet accepted when in_valid && in_ready
//  out_valid  out  1            beat valid
//  out_data   out  LANE_DATAW   same header fields; tmask and rs1/2/3 narrowed to NUM_LANES
//  out_pid    out  PID_W        batch index of this beat
//  out_sop    out  1            first emitted beat of the packet
//  out_eop    out  1            last emitted beat of the packet
//  out_ready  in   1            beat consumed when out_valid && out_ready
// BEHAVIOUR
//  - Reset (async assert, sync-released flops): buffer empty; out_valid, out_pid, out_sop, out_eop and
//    out_data all 0; pending mask 0. in_ready = 1 once reset_n is high.
//  - Storage: one packet register (buf_valid, buf_data) and a BATCHES-bit pending mask.
//  - Accept: in_ready = !buf_valid || (out_valid && out_ready && out_eop). An accepted packet loads
//    buf_data and pending[b] = |tmask[b*NUM_LANES +: NUM_LANES].
//  - All-zero tmask: pending = 1 (batch 0 only). One beat is emitted with pid 0, sop = eop = 1 and
//    tmask 0, so writeback and scoreboard bookkeeping still complete.
//  - States: IDLE (!buf_valid) -> SEND on accept. SEND -> IDLE on an eop fire with no new accept.
//    SEND -> SEND (new packet loaded) on an eop fire with a simultaneous accept.
//  - Beat selection: out_pid = index of the lowest set bit of pending.
//    out_eop = (pending has exactly one bit set). out_sop = first beat since load (sop flag register).
//  - On a non-eop fire: clear pending[out_pid] and clear sop.
//  - Latency: 1 cycle from in fire to first out_valid. Back-to-back packets have no bubble; steady
//    throughput is 1 beat per cycle.
//  - out_* are registered/derived from buffer state only; no combinational path from in_* to out_*.
//    out_valid must not drop, and out_data/out_pid must hold stable, while out_valid && !out_ready.
//  - out_data lane slice = rs*/tmask bits [out_pid*NUM_LANES +: NUM_LANES]. Header fields are copied
//    unchanged on every beat.
//  - BATCHES == 1: out_pid = 0, sop = eop = 1, pure 1-entry pipe register.
//  - Reset mid-packet: remaining beats are discarded with no eop. The next packet starts at sop.
// STRUCTURE
//  - Shared package gets: operands data_t / lane_data_t typedefs, OPS_DATAW, LANE_DATAW, and the
//    PID_W function. The operands interface reuses these typedefs.
//  - One sub-module: vx_lane_batch_picker. Combinational: pending mask -> pid, onehot, is_last.
//    Uses lowest-set-bit priority encoding.
//  - Lane slicing lives inline (generate loop).
// TESTING  (THREAD_CNT=4, NUM_LANES=2, out_ready=1 unless stated)
//  1. tmask=4'b1111, rs1={t3..t0}={3,2,1,0}:
//     beat A: pid0 rs1={1,0} sop=1 eop=0; beat B: pid1 rs1={3,2} sop=0 eop=1; in_ready=1 with beat B.
//  2. tmask=4'b1100 -> single beat pid1 tmask=2'b11 sop=eop=1. Batch 0 never emitted.
//  3. tmask=4'b0000 -> single beat pid0 tmask=2'b00 sop=eop=1.
//  4. tmask=4'b1111, out_ready low for 3 cycles on beat pid0:
//     out_data/pid/sop held stable; in_ready=0; 2 beats total after release.
//  5. Two packets presented back-to-back, uuid 7 then uuid 8:
//     beats uuid7 pid0, uuid7 pid1, uuid8 pid0, uuid8 pid1 on 4 consecutive cycles.
//  6. reset_n low while uuid 9 pid1 is pending:
//     out_valid=0 immediately (async); next packet uuid 10 emits pid0 with sop=1.

Source files
------------

// File: rtl/vx_operands_lane_serializer_pkg.sv
// rtl/vx_operands_lane_serializer_pkg.sv - shared operand packet types and widths
//
// Purpose: operand packet header layout, default full-warp (data_t) and
//   per-beat (lane_data_t) packet types, their widths, and width helpers
//   used to size parameterised ports.
// Ports: none (package).
package vx_operands_lane_serializer_pkg;

  localparam int XLEN          = 32;
  localparam int NUM_THREADS   = 4;
  localparam int NUM_LANES_DEF = 2;

  typedef struct packed {
    logic [31:0] uuid;
    logic [1:0]  wis;
    logic [31:0] pc;
    logic [2:0]  ex_type;
    logic [3:0]  op_type;
    logic [2:0]  op_mod;
    logic        wb;
    logic        use_pc;
    logic        use_imm;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        is_branch;
  } hdr_t;

  localparam int HDR_W = $bits(hdr_t);

  typedef struct packed {
    hdr_t                              hdr;
    logic [NUM_THREADS-1:0]            tmask;
    logic [NUM_THREADS-1:0][XLEN-1:0]  rs1;
    logic [NUM_THREADS-1:0][XLEN-1:0]  rs2;
    logic [NUM_THREADS-1:0][XLEN-1:0]  rs3;
  } data_t;

  typedef struct packed {
    hdr_t                                hdr;
    logic [NUM_LANES_DEF-1:0]            tmask;
    logic [NUM_LANES_DEF-1:0][XLEN-1:0]  rs1;
    logic [NUM_LANES_DEF-1:0][XLEN-1:0]  rs2;
    logic [NUM_LANES_DEF-1:0][XLEN-1:0]  rs3;
  } lane_data_t;

  localparam int OPS_DATAW  = $bits(data_t);
  localparam int LANE_DATAW = $bits(lane_data_t);

  // Packet width for an arbitrary thread/lane count (header + tmask + 3 regs).
  function automatic int ops_dataw(input int threads);
    return HDR_W + threads * (1 + 3 * XLEN);
  endfunction

  function automatic int pid_w(input int batches);
    return (batches <= 1) ? 1 : $clog2(batches);
  endfunction

endpackage

// File: rtl/vx_lane_batch_picker.sv
// rtl/vx_lane_batch_picker.sv - lowest-pending-batch selector
//
// Purpose: combinational pick of the next batch to emit from a pending mask.
// Ports:
//   i_pending  BATCHES  batches still to emit
//   o_pid      PID_W    index of the lowest set bit (0 when mask empty)
//   o_onehot   BATCHES  one-hot of the selected batch
//   o_is_last  1        selected batch is the only one left
module vx_lane_batch_picker
  import vx_operands_lane_serializer_pkg::*;
#(
  parameter int BATCHES = 2,
  parameter int PID_W   = pid_w(BATCHES)
) (
  input  logic [BATCHES-1:0] i_pending,
  output logic [PID_W-1:0]   o_pid,
  output logic [BATCHES-1:0] o_onehot,
  output logic               o_is_last
);

  logic w_found;

  always_comb begin
    o_pid    = '0;
    o_onehot = '0;
    w_found  = 1'b0;
    for (int b = 0; b < BATCHES; b++) begin
      if (i_pending[b] && !w_found) begin
        o_onehot[b] = 1'b1;
        o_pid       = b[PID_W-1:0];
        w_found     = 1'b1;
      end
    end
    // Last beat when nothing remains once the selected batch is removed.
    o_is_last = w_found && ((i_pending & ~o_onehot) == '0);
  end

endmodule

// File: rtl/vx_operands_lane_serializer.sv
// rtl/vx_operands_lane_serializer.sv - full-warp operand packet to lane-beat serializer
//
// Purpose: buffers one operand packet and replays it as NUM_LANES-wide beats,
//   skipping batches whose tmask slice is zero. An all-zero tmask still emits
//   one empty beat (pid 0) so downstream bookkeeping completes.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid/in_data/in_ready    full-warp operand packet input
//   out_valid/out_data/out_ready lane beat output
//   out_pid, out_sop, out_eop    batch index, first/last beat of packet
module vx_operands_lane_serializer
  import vx_operands_lane_serializer_pkg::*;
#(
  parameter  int THREAD_CNT = NUM_THREADS,
  parameter  int NUM_LANES  = NUM_LANES_DEF,
  localparam int BATCHES    = THREAD_CNT / NUM_LANES,
  localparam int PID_W      = pid_w(BATCHES),
  localparam int IN_W       = ops_dataw(THREAD_CNT),
  localparam int OUT_W      = ops_dataw(NUM_LANES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic [PID_W-1:0] out_pid,
  output logic             out_sop,
  output logic             out_eop,
  input  logic             out_ready
);

  typedef struct packed {
    hdr_t                             hdr;
    logic [THREAD_CNT-1:0]            tmask;
    logic [THREAD_CNT-1:0][XLEN-1:0]  rs1;
    logic [THREAD_CNT-1:0][XLEN-1:0]  rs2;
    logic [THREAD_CNT-1:0][XLEN-1:0]  rs3;
  } pkt_t;

  typedef struct packed {
    hdr_t                            hdr;
    logic [NUM_LANES-1:0]            tmask;
    logic [NUM_LANES-1:0][XLEN-1:0]  rs1;
    logic [NUM_LANES-1:0][XLEN-1:0]  rs2;
    logic [NUM_LANES-1:0][XLEN-1:0]  rs3;
  } lane_t;

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  pkt_t               r_buf;
  logic [BATCHES-1:0] r_pending;
  logic               r_sop;

  pkt_t               w_in;
  logic               w_fire;
  logic               w_accept;
  logic               w_last;
  logic [PID_W-1:0]   w_pid;
  logic [BATCHES-1:0] w_onehot;
  logic [BATCHES-1:0] w_in_slices;
  logic [BATCHES-1:0] w_in_pending;
  lane_t              w_slice [BATCHES];
  lane_t              w_lane;

  assign w_in = pkt_t'(in_data);

  vx_lane_batch_picker #(
    .BATCHES (BATCHES),
    .PID_W   (PID_W)
  ) u_picker (
    .i_pending (r_pending),
    .o_pid     (w_pid),
    .o_onehot  (w_onehot),
    .o_is_last (w_last)
  );

  for (genvar b = 0; b < BATCHES; b++) begin : g_batch
    assign w_in_slices[b] = |w_in.tmask[b*NUM_LANES +: NUM_LANES];
    assign w_slice[b] = '{
      hdr:   r_buf.hdr,
      tmask: r_buf.tmask[b*NUM_LANES +: NUM_LANES],
      rs1:   r_buf.rs1[b*NUM_LANES +: NUM_LANES],
      rs2:   r_buf.rs2[b*NUM_LANES +: NUM_LANES],
      rs3:   r_buf.rs3[b*NUM_LANES +: NUM_LANES]
    };
  end

  // An empty warp still needs one (empty) beat, carried on batch 0.
  always_comb begin
    w_in_pending = w_in_slices;
    if (w_in_slices == '0) w_in_pending[0] = 1'b1;
  end

  always_comb begin
    w_lane = '0;
    for (int b = 0; b < BATCHES; b++) begin
      if (w_onehot[b]) w_lane = w_slice[b];
    end
  end

  assign out_data = w_lane;
  assign out_pid  = w_pid;
  assign out_sop  = r_sop;
  assign out_eop  = w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b1;
    out_valid   = 1'b0;
    w_fire      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_accept = in_valid;
        if (in_valid) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        out_valid = 1'b1;
        w_fire    = out_ready;
        // The buffer frees up in the same cycle its last beat leaves.
        in_ready  = out_ready && w_last;
        w_accept  = in_valid && in_ready;
        if (w_fire && w_last && !in_valid) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf     <= '0;
      r_pending <= '0;
      r_sop     <= 1'b0;
    end else if (w_accept) begin
      r_buf     <= w_in;
      r_pending <= w_in_pending;
      r_sop     <= 1'b1;
    end else if (w_fire) begin
      r_pending <= r_pending & ~w_onehot;
      r_sop     <= 1'b0;
    end
  end

endmodule
